// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-port SRAM arbiter.
// Port select, outstanding-queue entry and window defaults.
package sram_arb_pkg;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  typedef struct packed {
    port_e port;
    logic  err;
  } outst_t;

  localparam logic [31:0] MEM_START_DEF = 32'h0000_0000;
  localparam int          MEM_SIZE_DEF  = 16384;

endpackage

// File: rtl/sram_arb_fifo.sv
// Outstanding-request queue: records {port, err} per grant so that
// responses are steered back in grant order.
module sram_arb_fifo
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  outst_t entry_i,
  input  logic   pop_i,
  output logic   full_o,
  output logic   empty_o,
  output outst_t head_o
);

  localparam int PW = $clog2(DEPTH);

  outst_t        mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= entry_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop_i) rptr_q <= rptr_q + 1'b1;
      if (push_i && !pop_i) cnt_q <= cnt_q + 1'b1;
      else if (pop_i && !push_i) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter of instruction and data ports onto one SRAM,
// with out-of-range requests answered locally with an error.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter logic [31:0] MEM_START   = MEM_START_DEF,
  parameter int          MEM_SIZE    = MEM_SIZE_DEF,
  parameter int          OUTST_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  port_e  last_q, last_d;
  port_e  hold_port_q, hold_port_d;
  logic   hold_q, hold_d;
  port_e  winner;
  logic   win_req, win_we, in_rng, tryg, granted;
  logic [3:0]  win_be;
  logic [31:0] win_addr, win_wdata;
  logic   full, empty, pop;
  outst_t head;

  always_comb begin
    winner = PORT_INSTR;
    if (hold_q)
      winner = hold_port_q;
    else if (instr_req_i && data_req_i)
      winner = (last_q == PORT_DATA) ? PORT_INSTR : PORT_DATA;
    else if (data_req_i)
      winner = PORT_DATA;
  end

  // Instruction fetches are always full-word reads.
  always_comb begin
    if (winner == PORT_INSTR) begin
      win_req   = instr_req_i;
      win_addr  = instr_addr_i;
      win_we    = 1'b0;
      win_be    = 4'hF;
      win_wdata = '0;
    end else begin
      win_req   = data_req_i;
      win_addr  = data_addr_i;
      win_we    = data_we_i;
      win_be    = data_be_i;
      win_wdata = data_wdata_i;
    end
  end

  assign in_rng  = (win_addr - MEM_START) < 32'(MEM_SIZE);
  assign tryg    = win_req && !full && !rst_i;
  assign granted = tryg && (!in_rng || mem_gnt_i);

  assign mem_req_o   = tryg && in_rng;
  assign mem_we_o    = mem_req_o && win_we;
  assign mem_be_o    = mem_req_o ? win_be : '0;
  assign mem_addr_o  = mem_req_o ? win_addr : '0;
  assign mem_wdata_o = mem_req_o ? win_wdata : '0;

  assign instr_gnt_o = granted && (winner == PORT_INSTR);
  assign data_gnt_o  = granted && (winner == PORT_DATA);

  always_comb begin
    last_d      = last_q;
    hold_d      = 1'b0;
    hold_port_d = hold_port_q;
    if (granted) last_d = winner;
    if (mem_req_o && !mem_gnt_i) begin
      hold_d      = 1'b1;
      hold_port_d = winner;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q      <= PORT_DATA;
      hold_q      <= 1'b0;
      hold_port_q <= PORT_INSTR;
    end else begin
      last_q      <= last_d;
      hold_q      <= hold_d;
      hold_port_q <= hold_port_d;
    end
  end

  sram_arb_fifo #(.DEPTH(OUTST_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (granted),
    .entry_i ('{port: winner, err: !in_rng}),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  // Error entries retire without waiting on the SRAM.
  assign pop = !rst_i && !empty && (head.err || mem_rvalid_i);

  assign instr_rvalid_o = pop && (head.port == PORT_INSTR);
  assign data_rvalid_o  = pop && (head.port == PORT_DATA);
  assign instr_err_o    = instr_rvalid_o && head.err;
  assign data_err_o     = data_rvalid_o && head.err;
  assign instr_rdata_o  = (instr_rvalid_o && !head.err) ? mem_rdata_i : '0;
  assign data_rdata_o   = (data_rvalid_o && !head.err) ? mem_rdata_i : '0;

  a_rvalid_expected: assert property (
    @(posedge clk_i) disable iff (rst_i)
    mem_rvalid_i |-> (!empty && !head.err)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with hand-computed expectations.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_addr, instr_rdata;
  logic        data_req, data_gnt, data_rvalid, data_we, data_err;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .instr_req_i    (instr_req),
    .instr_gnt_o    (instr_gnt),
    .instr_rvalid_o (instr_rvalid),
    .instr_addr_i   (instr_addr),
    .instr_rdata_o  (instr_rdata),
    .instr_err_o    (instr_err),
    .data_req_i     (data_req),
    .data_gnt_o     (data_gnt),
    .data_rvalid_o  (data_rvalid),
    .data_we_i      (data_we),
    .data_be_i      (data_be),
    .data_addr_i    (data_addr),
    .data_wdata_i   (data_wdata),
    .data_rdata_o   (data_rdata),
    .data_err_o     (data_err),
    .mem_req_o      (mem_req),
    .mem_gnt_i      (mem_gnt),
    .mem_we_o       (mem_we),
    .mem_be_o       (mem_be),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rvalid_i   (mem_rvalid),
    .mem_rdata_i    (mem_rdata)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic idle();
    instr_req = 0; data_req = 0; data_we = 0; data_be = 4'hF;
    mem_rvalid = 0; mem_rdata = 0; mem_gnt = 1;
  endtask

  initial begin
    rst = 1; idle();
    instr_addr = 0; data_addr = 0; data_wdata = 0;
    instr_req = 1; mem_rvalid = 1; mem_rdata = 32'hDEAD;
    nxt(); #1;
    chk("rst_gnt", instr_gnt, 1'b0);
    chk("rst_memreq", mem_req, 1'b0);
    chk("rst_rvalid", instr_rvalid, 1'b0);
    chk("rst_rdata", instr_rdata, 32'h0);

    nxt(); rst = 0; idle();
    nxt();
    instr_req = 1; instr_addr = 32'h100;
    data_req = 1; data_addr = 32'h200;
    #1;
    chk("rr0_igen", instr_gnt, 1'b1);
    chk("rr0_dgnt", data_gnt, 1'b0);
    chk("rr0_addr", mem_addr, 32'h100);
    chk("rr0_be", mem_be, 4'hF);
    nxt(); instr_addr = 32'h104; #1;
    chk("rr1_dgnt", data_gnt, 1'b1);
    chk("rr1_igen", instr_gnt, 1'b0);
    chk("rr1_addr", mem_addr, 32'h200);
    nxt(); data_req = 0; instr_addr = 32'h300;
    mem_rvalid = 1; mem_rdata = 32'hAAAA; #1;
    chk("full_igen", instr_gnt, 1'b0);
    chk("full_memreq", mem_req, 1'b0);
    chk("rsp0_iv", instr_rvalid, 1'b1);
    chk("rsp0_ird", instr_rdata, 32'hAAAA);
    chk("rsp0_dv", data_rvalid, 1'b0);
    nxt(); instr_req = 0; mem_rdata = 32'hBBBB; #1;
    chk("rsp1_dv", data_rvalid, 1'b1);
    chk("rsp1_drd", data_rdata, 32'hBBBB);
    chk("rsp1_iv", instr_rvalid, 1'b0);
    chk("rsp1_ird", instr_rdata, 32'h0);

    nxt(); idle(); data_req = 1; data_addr = 32'h0000_4000; #1;
    chk("oor_gnt", data_gnt, 1'b1);
    chk("oor_memreq", mem_req, 1'b0);
    nxt(); idle(); #1;
    chk("oor_rv", data_rvalid, 1'b1);
    chk("oor_err", data_err, 1'b1);
    chk("oor_rd", data_rdata, 32'h0);
    nxt(); #1;
    chk("oor_done", data_rvalid, 1'b0);

    instr_req = 1; instr_addr = 32'h500; mem_gnt = 0;
    data_req = 1; data_addr = 32'h600; data_we = 1;
    data_be = 4'h3; data_wdata = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_igen", instr_gnt, 1'b0);
      chk("stall_dgnt", data_gnt, 1'b0);
      chk("stall_req", mem_req, 1'b1);
      chk("stall_addr", mem_addr, 32'h500);
      chk("stall_we", mem_we, 1'b0);
      nxt();
    end
    mem_gnt = 1; #1;
    chk("stall_rel", instr_gnt, 1'b1);
    chk("stall_reld", data_gnt, 1'b0);
    nxt(); instr_req = 0; #1;
    chk("wr_gnt", data_gnt, 1'b1);
    chk("wr_we", mem_we, 1'b1);
    chk("wr_be", mem_be, 4'h3);
    chk("wr_wd", mem_wdata, 32'h1234);

    for (int i = 0; i < 2; i++) begin
      nxt(); #1;
      chk("wh_gnt", data_gnt, 1'b0);
    end
    nxt(); mem_rvalid = 1; mem_rdata = 32'h55; #1;
    chk("wh_gnt_pop", data_gnt, 1'b0);
    chk("wh_iv", instr_rvalid, 1'b1);
    chk("wh_ird", instr_rdata, 32'h55);
    nxt(); mem_rvalid = 0; #1;
    chk("wh_regnt", data_gnt, 1'b1);
    nxt(); data_req = 0; mem_rvalid = 1; mem_rdata = 32'h0; #1;
    chk("wh_dv0", data_rvalid, 1'b1);
    chk("wh_de0", data_err, 1'b0);
    nxt(); mem_rdata = 32'h77; #1;
    chk("wh_dv1", data_rvalid, 1'b1);
    chk("wh_drd1", data_rdata, 32'h77);

    nxt(); idle(); instr_req = 1; instr_addr = 32'h700; #1;
    chk("ord_igen", instr_gnt, 1'b1);
    nxt(); instr_req = 0; data_req = 1; data_addr = 32'h8000_0000; #1;
    chk("ord_dgnt", data_gnt, 1'b1);
    chk("ord_memreq", mem_req, 1'b0);
    nxt(); data_req = 0; #1;
    chk("ord_wait_d", data_rvalid, 1'b0);
    chk("ord_wait_i", instr_rvalid, 1'b0);
    nxt(); mem_rvalid = 1; mem_rdata = 32'hCAFE; #1;
    chk("ord_iv", instr_rvalid, 1'b1);
    chk("ord_ird", instr_rdata, 32'hCAFE);
    chk("ord_dv_early", data_rvalid, 1'b0);
    nxt(); mem_rvalid = 0; #1;
    chk("ord_dv", data_rvalid, 1'b1);
    chk("ord_de", data_err, 1'b1);

    nxt(); idle(); data_req = 1; data_addr = 32'h10; #1;
    chk("pre_dgnt", data_gnt, 1'b1);
    nxt(); data_req = 0; instr_req = 1; instr_addr = 32'h20; #1;
    chk("pre_igen", instr_gnt, 1'b1);
    nxt(); idle(); rst = 1; mem_rvalid = 1; mem_rdata = 32'h99; #1;
    chk("rst_iv", instr_rvalid, 1'b0);
    chk("rst_dv", data_rvalid, 1'b0);
    chk("rst_drd", data_rdata, 32'h0);
    nxt(); mem_rvalid = 0; rst = 0;
    nxt();
    instr_req = 1; instr_addr = 32'h30; data_req = 1; data_addr = 32'h40;
    #1;
    chk("post_igen", instr_gnt, 1'b1);
    chk("post_dgnt", data_gnt, 1'b0);
    nxt(); #1;
    chk("post_dgnt2", data_gnt, 1'b1);
    chk("post_rv", instr_rvalid, 1'b0);
    nxt(); idle();
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
